// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - command codes, frame lengths and FSM state for the command encoder
// ENCODER_CHECKSUM_EN adds one trailing XOR byte to every frame.
package cmd_pkg;

  localparam logic [7:0] CMD_PERIOD = 8'h01;
  localparam logic [7:0] CMD_FREQ   = 8'h02;
  localparam logic [7:0] CMD_DATA   = 8'h03;
  localparam logic [7:0] CMD_CTRL   = 8'h04;
  localparam logic [7:0] CMD_REPEAT = 8'h05;

  localparam int LEN_PERIOD   = 3;
  localparam int LEN_FREQ_HDR = 1;
  localparam int LEN_DATA_HDR = 2;
  localparam int LEN_CTRL     = 3;
  localparam int LEN_REPEAT   = 3;

  localparam int CSUM_W = 8;
`ifdef ENCODER_CHECKSUM_EN
  localparam int LEN_CSUM = 1;
`else
  localparam int LEN_CSUM = 0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  // CMD_DATA is always the longest frame.
  function automatic int max_frame_len(int data_bit);
    return LEN_DATA_HDR + data_bit / 8 + LEN_CSUM;
  endfunction

endpackage

// File: rtl/cmd_frame_len.sv
// rtl/cmd_frame_len.sv - combinational frame length lookup per command code
// Length includes the checksum byte when ENCODER_CHECKSUM_EN is defined.
module cmd_frame_len
  import cmd_pkg::*;
#(
  parameter int DATA_BIT = 32,
  parameter int LEN_W    = 4
) (
  input  logic [7:0]       cmd,
  output logic [LEN_W-1:0] len,
  output logic             valid
);

  always_comb begin
    valid = 1'b1;
    len   = '0;
    case (cmd)
      CMD_PERIOD: len = LEN_W'(LEN_PERIOD + LEN_CSUM);
      CMD_FREQ:   len = LEN_W'(LEN_FREQ_HDR + DATA_BIT / 8 + LEN_CSUM);
      CMD_DATA:   len = LEN_W'(LEN_DATA_HDR + DATA_BIT / 8 + LEN_CSUM);
      CMD_CTRL:   len = LEN_W'(LEN_CTRL + LEN_CSUM);
      CMD_REPEAT: len = LEN_W'(LEN_REPEAT + LEN_CSUM);
      default:    valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmd_encoder.sv
// rtl/cmd_encoder.sv - frames one host command into bytes and feeds a UART transmitter
// ENCODER_CHECKSUM_EN appends the XOR of all preceding frame bytes.
module cmd_encoder
  import cmd_pkg::*;
#(
  parameter int DATA_BIT      = 32,
  parameter int UART_DATA_BIT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [7:0]               cmd_i,
  input  logic [7:0]               channel_i,
  input  logic [DATA_BIT-1:0]      payload_i,
  input  logic                     tx_done_tick_i,
  output logic                     tx_start_o,
  output logic [UART_DATA_BIT-1:0] tx_data_o,
  output logic                     busy_o,
  output logic                     done_tick_o,
  output logic                     err_o
);

  localparam int MAX_LEN = max_frame_len(DATA_BIT);
  localparam int IDX_W   = $clog2(MAX_LEN + 1);

  state_t                   state, state_nxt;
  logic [7:0]               cmd_q, ch_q;
  logic [DATA_BIT-1:0]      pay_q;
  logic [IDX_W-1:0]         idx, len_q, len_w;
  logic                     len_ok;
  logic                     loaded;
  logic                     last;
  logic [UART_DATA_BIT-1:0] data_q;
  logic [7:0]               sel_byte;
  logic [IDX_W-1:0]         pay_k;
  logic [DATA_BIT-1:0]      shifted;
`ifdef ENCODER_CHECKSUM_EN
  logic [CSUM_W-1:0]        csum;
`endif

  cmd_frame_len #(
    .DATA_BIT (DATA_BIT),
    .LEN_W    (IDX_W)
  ) u_len (
    .cmd   (cmd_i),
    .len   (len_w),
    .valid (len_ok)
  );

  assign last      = (idx == len_q - IDX_W'(1));
  assign tx_data_o = data_q;

  // Payload byte k: pattern bytes start after the header (1 byte, or 2 for CMD_DATA).
  always_comb begin
    pay_k    = idx - ((cmd_q == CMD_DATA) ? IDX_W'(2) : IDX_W'(1));
    shifted  = pay_q >> {pay_k, 3'b000};
    sel_byte = shifted[7:0];
    case (cmd_q)
      CMD_PERIOD, CMD_FREQ: sel_byte = shifted[7:0];
      CMD_DATA:             sel_byte = (idx == IDX_W'(1)) ? ch_q : shifted[7:0];
      default:              sel_byte = (idx == IDX_W'(1)) ? ch_q : pay_q[7:0];
    endcase
`ifdef ENCODER_CHECKSUM_EN
    if (last) sel_byte = csum;
`endif
  end

  always_comb begin
    state_nxt   = state;
    tx_start_o  = 1'b0;
    busy_o      = 1'b0;
    done_tick_o = 1'b0;
    err_o       = 1'b0;
    case (state)
      S_IDLE: if (start_i) state_nxt = len_ok ? S_SEND : S_ERR;
      S_SEND: begin
        busy_o = 1'b1;
        if (loaded) begin
          tx_start_o = 1'b1;
          state_nxt  = S_WAIT;
        end
      end
      S_WAIT: begin
        busy_o = 1'b1;
        if (tx_done_tick_i) state_nxt = last ? S_DONE : S_SEND;
      end
      S_DONE: begin
        busy_o      = 1'b1;
        done_tick_o = 1'b1;
        state_nxt   = S_IDLE;
      end
      S_ERR: begin
        err_o     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The cmd byte is loaded at accept; later bytes spend one SEND cycle loading
  // tx_data_o before the start pulse so the byte is stable under tx_start_o.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state  <= S_IDLE;
      cmd_q  <= '0;
      ch_q   <= '0;
      pay_q  <= '0;
      len_q  <= '0;
      idx    <= '0;
      loaded <= 1'b0;
      data_q <= '0;
`ifdef ENCODER_CHECKSUM_EN
      csum   <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start_i && len_ok) begin
            cmd_q  <= cmd_i;
            ch_q   <= channel_i;
            pay_q  <= payload_i;
            len_q  <= len_w;
            idx    <= '0;
            data_q <= UART_DATA_BIT'(cmd_i);
            loaded <= 1'b1;
`ifdef ENCODER_CHECKSUM_EN
            csum   <= cmd_i;
`endif
          end
        end
        S_SEND: begin
          if (loaded) begin
            loaded <= 1'b0;
          end else begin
            data_q <= UART_DATA_BIT'(sel_byte);
            loaded <= 1'b1;
`ifdef ENCODER_CHECKSUM_EN
            csum   <= csum ^ sel_byte;
`endif
          end
        end
        S_WAIT: if (tx_done_tick_i && !last) idx <= idx + IDX_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_encoder.sv
// tb/tb_cmd_encoder.sv - scoreboard bench for cmd_encoder with a UART responder model
// Follows ENCODER_CHECKSUM_EN to expect the trailing XOR byte.
module tb_cmd_encoder;
  import cmd_pkg::*;

  localparam int DB = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start_i = 1'b0;
  logic [7:0]    cmd_i = '0;
  logic [7:0]    channel_i = '0;
  logic [DB-1:0] payload_i = '0;
  logic          tx_done_tick_i = 1'b0;
  logic          tx_start_o;
  logic [7:0]    tx_data_o;
  logic          busy_o;
  logic          done_tick_o;
  logic          err_o;

  int         tests = 0;
  int         fails = 0;
  int         epoch = 0;
  int         dones_exp = 0;
  int         dones_seen = 0;
  logic [7:0] exp_q[$];

  cmd_encoder #(.DATA_BIT(DB), .UART_DATA_BIT(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .cmd_i          (cmd_i),
    .channel_i      (channel_i),
    .payload_i      (payload_i),
    .tx_done_tick_i (tx_done_tick_i),
    .tx_start_o     (tx_start_o),
    .tx_data_o      (tx_data_o),
    .busy_o         (busy_o),
    .done_tick_o    (done_tick_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit is_known(logic [7:0] c);
    return c == CMD_PERIOD || c == CMD_FREQ || c == CMD_DATA || c == CMD_CTRL || c == CMD_REPEAT;
  endfunction

  // Reference frame: byte list built straight from the command layout.
  task automatic push_frame(input logic [7:0] c, input logic [7:0] ch, input logic [DB-1:0] p);
    logic [7:0] b[$];
    logic [7:0] x;
    b.push_back(c);
    if (c == CMD_PERIOD) begin
      b.push_back(p[7:0]);
      b.push_back(p[15:8]);
    end else if (c == CMD_FREQ || c == CMD_DATA) begin
      if (c == CMD_DATA) b.push_back(ch);
      for (int i = 0; i < DB / 8; i++) b.push_back(8'((p >> (8 * i)) & 32'hFF));
    end else begin
      b.push_back(ch);
      b.push_back(p[7:0]);
    end
`ifdef ENCODER_CHECKSUM_EN
    x = 8'h00;
    foreach (b[i]) x ^= b[i];
    b.push_back(x);
`else
    x = 8'h00;
`endif
    foreach (b[i]) exp_q.push_back(b[i]);
  endtask

  // Monitor: every start pulse must match the next expected byte, and the byte must hold.
  logic [7:0] hold_byte = '0;
  bit         holding = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      holding = 0;
    end else begin
      if (tx_start_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_tx_start", {24'h0, tx_data_o}, 32'hFFFF_FFFF);
        end else begin
          chk("frame_byte", {24'h0, tx_data_o}, {24'h0, exp_q.pop_front()});
        end
        hold_byte = tx_data_o;
        holding = 1;
      end else if (holding && busy_o) begin
        if (tx_data_o !== hold_byte) chk("tx_data_stable", {24'h0, tx_data_o}, {24'h0, hold_byte});
      end else begin
        holding = 0;
      end
      if (done_tick_o) begin
        chk("done_after_last_byte", exp_q.size(), 0);
        dones_seen++;
      end
    end
  end

  // UART responder with random latency; checks the post-done timing when no reset intervened.
  initial begin : uart_model
    bit at_start;
    int ep;
    int rem;
    at_start = 0;
    forever begin
      if (!at_start) begin
        @(negedge clk);
        while (!(tx_start_o === 1'b1 && rst_n === 1'b0)) @(negedge clk);
      end
      at_start = 0;
      ep = epoch;
      @(posedge clk);
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1 tx_done_tick_i = 1'b1;
      @(posedge clk);
      rem = exp_q.size();
      #1 tx_done_tick_i = 1'b0;
      if (ep == epoch) begin
        @(negedge clk);
        if (rem == 0) begin
          chk("done_tick_m1", done_tick_o, 1);
          chk("busy_at_done", busy_o, 1);
        end else begin
          chk("no_start_m1", tx_start_o, 0);
        end
        @(negedge clk);
        if (rem == 0) begin
          chk("idle_m2", busy_o, 0);
        end else begin
          chk("next_start_m2", tx_start_o, 1);
          at_start = tx_start_o;
        end
      end
    end
  end

  task automatic send_cmd(input logic [7:0] c, input logic [7:0] ch, input logic [DB-1:0] p,
                          input bit inject);
    bit known;
    int n;
    known = is_known(c);
    @(posedge clk);
    #1;
    cmd_i = c;
    channel_i = ch;
    payload_i = p;
    start_i = 1'b1;
    if (known) begin
      push_frame(c, ch, p);
      dones_exp++;
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
    cmd_i = 8'($urandom);
    channel_i = 8'($urandom);
    payload_i = $urandom;
    @(negedge clk);
    if (known) begin
      chk("accept_tx_start", tx_start_o, 1);
      chk("accept_busy", busy_o, 1);
      chk("accept_no_err", err_o, 0);
      if (inject) begin
        @(posedge clk);
        #1;
        cmd_i = CMD_PERIOD;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
      end
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (done_tick_o !== 1'b1 && n < 3000);
      if (done_tick_o !== 1'b1) chk("frame_timeout", 0, 1);
    end else begin
      chk("err_pulse", err_o, 1);
      chk("err_busy_low", busy_o, 0);
      chk("err_no_tx_start", tx_start_o, 0);
      @(negedge clk);
      chk("err_one_cycle", err_o, 0);
    end
  endtask

  task automatic reset_mid_data();
    int n;
    @(posedge clk);
    #1;
    cmd_i = CMD_DATA;
    channel_i = 8'h05;
    payload_i = 32'hBBCCDDEE;
    start_i = 1'b1;
    push_frame(CMD_DATA, 8'h05, 32'hBBCCDDEE);
    n = exp_q.size();
    @(posedge clk);
    #1;
    start_i = 1'b0;
    for (int i = 0; i < 3000 && exp_q.size() > n - 2; i++) @(negedge clk);
    chk("reset_two_bytes_sent", exp_q.size(), n - 2);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    epoch++;
    exp_q.delete();
    #1;
    chk("rst_tx_start", tx_start_o, 0);
    chk("rst_tx_data", {24'h0, tx_data_o}, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_tick_o, 0);
    chk("rst_err", err_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_bytes_after_reset", exp_q.size(), 0);
  endtask

  initial begin : stim
    logic [7:0] c;
    repeat (3) @(negedge clk);
    chk("reset_tx_start", tx_start_o, 0);
    chk("reset_tx_data", {24'h0, tx_data_o}, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_tick_o, 0);
    chk("reset_err", err_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;

    send_cmd(CMD_PERIOD, 8'h00, 32'h0000_0514, 0);
    send_cmd(CMD_FREQ,   8'h00, 32'h1122_3344, 0);
    send_cmd(CMD_DATA,   8'h05, 32'hBBCC_DDEE, 0);
    send_cmd(CMD_CTRL,   8'h05, 32'h0000_000B, 0);
    send_cmd(CMD_REPEAT, 8'h05, 32'h0000_0003, 0);
    send_cmd(8'hFF,      8'h00, 32'h0,         0);
    send_cmd(CMD_DATA,   8'h07, 32'h0102_0304, 1);
    send_cmd(8'h00,      8'h00, 32'h0,         0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) c = 8'($urandom);
      else c = 8'($urandom_range(1, 5));
      send_cmd(c, 8'($urandom), $urandom, $urandom_range(0, 3) == 0);
    end

    reset_mid_data();
    send_cmd(CMD_FREQ, 8'h00, 32'hCAFE_F00D, 0);

    repeat (10) @(negedge clk);
    chk("done_count", dones_seen, dones_exp);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cmd_encoder.md
# cmd_encoder

- Host-side counterpart of the command decoder: frames one user command (period, frequency pattern, data pattern, repeat count, control) into the byte sequence the decoder parses.
- Drives that sequence byte by byte into the UART transmitter through its start/done handshake.
- Used as the stimulus source in FPGA self-test and loopback builds, and as a bus-driven command injector when no PC host is attached.

## Interface
- DATA_BIT, 32, pattern width; multiple of 8; pattern frames carry DATA_BIT/8 bytes.
- UART_DATA_BIT, 8, UART byte width.
- clk  input  1  system clock.
- rst_n  input  1  reset rst_n, asynchronous, active-high.
- start_i  input  1  one-cycle request; sampled only in IDLE.
- cmd_i  input  8  command code (CMD_PERIOD, CMD_FREQ, CMD_DATA, CMD_CTRL, CMD_REPEAT).
- channel_i  input  8  channel index.
- payload_i  input  DATA_BIT  payload, mapped per command (see Operation).
- tx_done_tick_i  input  1  UART transmitter finished current byte.
- tx_start_o  output  1  one-cycle start pulse to UART transmitter.
- tx_data_o  output  UART_DATA_BIT  byte to send; held stable from tx_start_o until the matching tx_done_tick_i.
- busy_o  output  1  high from the accepted start until done/err.
- done_tick_o  output  1  one-cycle pulse when the whole frame has been sent.
- err_o  output  1  one-cycle pulse when an unknown cmd_i is rejected.

## Operation
- Frames (bytes in order, patterns LSB byte first):
  - CMD_PERIOD: cmd, payload[7:0] (slow), payload[15:8] (fast). 3 bytes.
  - CMD_FREQ: cmd, then DATA_BIT/8 pattern bytes. 5 bytes at default.
  - CMD_DATA: cmd, channel, then DATA_BIT/8 pattern bytes. 6 bytes at default.
  - CMD_CTRL: cmd, channel, payload[7:0] ({4'h0, idle, mode[1:0], en}). 3 bytes.
  - CMD_REPEAT: cmd, channel, payload[7:0]. 3 bytes.
- Inputs cmd_i, channel_i and payload_i are latched on the accepted start_i edge; later input changes do not affect the frame in flight.
- FSM states:
  - IDLE: on start_i with a known cmd, go to SEND. On start_i with an unknown cmd, go to ERR.
  - SEND: assert tx_start_o and present the current byte; go to WAIT.
  - WAIT: on tx_done_tick_i, go to DONE if this was the last byte, otherwise increment the byte index and go to SEND.
  - DONE: pulse done_tick_o; go to IDLE.
  - ERR: pulse err_o; go to IDLE.
- Byte index is a counter of width $clog2(max frame length + 1). The length comes from a per-command lookup.
- start_i while busy is ignored and not queued.
- tx_done_tick_i outside WAIT is ignored.

## Timing
- Reset values: tx_start_o=0, tx_data_o=0, busy_o=0, done_tick_o=0, err_o=0; FSM in IDLE; byte index 0.
- start_i accepted at edge N: busy_o=1 and tx_start_o=1 with the cmd byte in cycle N+1.
- tx_done_tick_i sampled at edge M: the next byte's tx_start_o is asserted in cycle M+2.
- Last tx_done_tick_i at edge M: done_tick_o=1 and busy_o=1 in cycle M+1; busy_o=0 from M+2. A new start_i is accepted at edge M+2.
- Unknown command: err_o=1 in cycle N+1; no tx_start_o is ever issued.
- Reset asserted mid-frame: outputs return to reset values immediately and the remaining bytes are dropped. The UART byte already in flight completes on its own; its tx_done_tick_i is ignored.

## Configuration
- ENCODER_CHECKSUM_EN defined: one extra trailing byte is sent, equal to the XOR of all preceding frame bytes, cmd byte included. Frame length grows by 1. The decoder build must enable the matching check.
- ENCODER_CHECKSUM_EN undefined: frames are exactly as listed in Operation, byte-compatible with the current decoder.

## Structure
- Shared package cmd_pkg holds:
  - command code constants (single source, shared with the decoder);
  - frame-length constants;
  - the FSM state typedef;
  - the checksum byte width.
- One sub-module: cmd_frame_len, a combinational map from cmd code and DATA_BIT to frame length plus a valid flag.
- Byte selection, counter and FSM stay in cmd_encoder.

## Test plan
- CMD_PERIOD, payload 0x0514 -> bytes CMD_PERIOD, 0x14, 0x05; then one done_tick_o.
- CMD_FREQ, payload 0x11223344 -> CMD_FREQ, 0x44, 0x33, 0x22, 0x11.
- CMD_DATA, channel 0x05, payload 0xBBCCDDEE -> CMD_DATA, 0x05, 0xEE, 0xDD, 0xCC, 0xBB. Loopback through UART and decoder yields output_pattern 0xBBCCDDEE and sel_out 5.
- CMD_CTRL, channel 5, payload 0x0B (idle high, continue, enable) -> CMD_CTRL, 0x05, 0x0B.
- cmd_i=0xFF -> err_o pulse in N+1, no tx_start_o, busy_o low. Then start_i during a frame -> ignored, frame unchanged.
- Reset after the 2nd byte of CMD_DATA -> no further tx_start_o, all outputs at reset values. With ENCODER_CHECKSUM_EN, CMD_REPEAT ch 5 rep 3 -> CMD_REPEAT, 0x05, 0x03, then CMD_REPEAT^0x06.
